// File: rtl/filt_pkg.sv
// Shared types and constants for the conversion sequencer.
// State encoding, accumulator sizing and saturation bounds.
package filt_pkg;

  typedef enum logic [3:0] {
    IDLE,
    READY,
    START,
    WAIT,
    MAC0,
    MAC1,
    MAC2,
    SCALE,
    EMIT
  } state_t;

  localparam int ACC_W   = 18;
  localparam int SHIFT_W = 4;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

endpackage

// File: rtl/filt_mac.sv
// Shared 8x8 signed multiplier with 18-bit accumulator,
// followed by arithmetic shift and saturation to 8 bits.
module filt_mac
  import filt_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     acc_en,
  input  logic                     sat_en,
  input  logic signed [7:0]        coef,
  input  logic signed [7:0]        sample,
  input  logic [SHIFT_W-1:0]       shift,
  output logic signed [7:0]        res
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_MIN);

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;

  assign prod    = coef * sample;
  assign ext     = {{(ACC_W-16){prod[15]}}, prod};
  assign shifted = acc >>> shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (clr)
        acc <= ext;
      else if (acc_en)
        acc <= acc + ext;
      if (sat_en) begin
        if (shifted > HI)
          res <= HI[7:0];
        else if (shifted < LO)
          res <= LO[7:0];
        else
          res <= shifted[7:0];
      end
    end
  end

endmodule

// File: rtl/filt_conv_sequencer.sv
// ADC conversion sequencer: paces starts, captures samples,
// runs a 3-tap FIR on a shared MAC and decimates the output.
module filt_conv_sequencer
  import filt_pkg::*;
#(
  parameter int SAMPLE_DIV  = 16,
  parameter int ADC_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       conv_en,
  input  logic [7:0] coef0,
  input  logic [7:0] coef1,
  input  logic [7:0] coef2,
  input  logic [7:0] coef_div,
  input  logic [1:0] decimation_ratio,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       busy,
  output logic       overrun,
  output logic       timeout
);

  state_t              state;
  logic                en_q;
  logic [7:0]          scnt;
  logic [7:0]          tcnt;
  logic [2:0]          dcnt;
  logic [2:0]          n_m1;
  logic signed [7:0]   x0, x1, x2;
  logic signed [7:0]   c0, c1, c2;
  logic [SHIFT_W-1:0]  shift;
  logic signed [7:0]   op_c, op_s;
  logic signed [7:0]   res;
  logic                tick;
  logic                rise;
  logic                unused_div;

  assign unused_div = ^coef_div[7:4];
  assign tick = (state != IDLE) && (scnt == 8'(SAMPLE_DIV - 1));
  assign rise = conv_en && !en_q;
  assign busy = (state != IDLE) && (state != READY);

  always_comb begin
    op_c = c0;
    op_s = x0;
    if (state == MAC1) begin
      op_c = c1;
      op_s = x1;
    end else if (state == MAC2) begin
      op_c = c2;
      op_s = x2;
    end
  end

  filt_mac u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == MAC0),
    .acc_en (state == MAC1 || state == MAC2),
    .sat_en (state == SCALE),
    .coef   (op_c),
    .sample (op_s),
    .shift  (shift),
    .res    (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_q      <= 1'b0;
      scnt      <= '0;
      tcnt      <= '0;
      dcnt      <= '0;
      n_m1      <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      c0        <= '0;
      c1        <= '0;
      c2        <= '0;
      shift     <= '0;
      adc_start <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      en_q      <= conv_en;
      adc_start <= 1'b0;
      out_valid <= 1'b0;
      if (state != IDLE)
        scnt <= tick ? 8'd0 : scnt + 8'd1;
      // a tick outside READY is dropped but remembered
      if (conv_en && tick && state != READY)
        overrun <= 1'b1;
      if (!conv_en) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (rise) begin
            state   <= READY;
            x0      <= '0;
            x1      <= '0;
            x2      <= '0;
            overrun <= 1'b0;
            timeout <= 1'b0;
            scnt    <= '0;
            dcnt    <= '0;
            n_m1    <= 3'((4'd1 << decimation_ratio) - 4'd1);
          end
          READY: if (tick) begin
            state     <= START;
            adc_start <= 1'b1;
          end
          START: begin
            c0    <= coef0;
            c1    <= coef1;
            c2    <= coef2;
            shift <= coef_div[SHIFT_W-1:0];
            tcnt  <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (adc_done) begin
              x2    <= x1;
              x1    <= x0;
              x0    <= adc_data;
              state <= MAC0;
            end else if (tcnt == 8'(ADC_TIMEOUT - 1)) begin
              timeout <= 1'b1;
              state   <= READY;
            end else begin
              tcnt <= tcnt + 8'd1;
            end
          end
          MAC0:  state <= MAC1;
          MAC1:  state <= MAC2;
          MAC2:  state <= SCALE;
          SCALE: state <= EMIT;
          EMIT: begin
            if (dcnt == n_m1) begin
              out_data  <= res;
              out_valid <= 1'b1;
              dcnt      <= '0;
            end else begin
              dcnt <= dcnt + 3'd1;
            end
            state <= READY;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
